byte_download_arbiter: RTL and testbench

// - N-channel successor to the two-channel switches/LED download interface: each producer presents a byte

---
 rtl/byte_download_arbiter_if.sv | 32 +++
 rtl/byte_download_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_byte_download_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_download_arbiter_if.sv
// byte_download_arbiter_if
// Bundles the producer handshake and FIFO read port of byte_download_arbiter.
// slave : seen by the arbiter. master : seen by the producer/reader side.
interface byte_download_arbiter_if #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CH-1:0]        ready_i;
  logic [NUM_CH*DATA_W-1:0] curbyte_i;
  logic [NUM_CH-1:0]        chan_en_i;
  logic [NUM_CH-1:0]        ack_o;
  logic                     rd_en_i;
  logic                     rd_valid_o;
  logic [DATA_W-1:0]        rd_data_o;
  logic [CH_W-1:0]          rd_ch_o;
  logic [CNT_W-1:0]         count_o;
  logic                     full_o;

  modport slave (
    input  ready_i, curbyte_i, chan_en_i, rd_en_i,
    output ack_o, rd_valid_o, rd_data_o, rd_ch_o, count_o, full_o
  );

  modport master (
    output ready_i, curbyte_i, chan_en_i, rd_en_i,
    input  ack_o, rd_valid_o, rd_data_o, rd_ch_o, count_o, full_o
  );
endinterface

// File: rtl/byte_download_arbiter.sv
// byte_download_arbiter
// N-channel round-robin byte download arbiter. Each producer raises ready with a
// byte; one channel at a time is granted, its byte is pushed as {channel, byte}
// into a show-ahead FIFO and acked with a 4-phase handshake (ack held until the
// producer drops ready). The Nios side drains the FIFO through rd_en_i.
// Optional macro READY_SYNC_EN: ready_i passes a 2-flop synchroniser per channel
// (ready-to-ack latency 3 clocks instead of 1).
//
// state    | meaning
// ---------+------------------------------------------------------------------
// IDLE     | no handshake open; grant next requesting channel if FIFO not full
// WAIT_LOW | byte captured, ack_o[g] high until ready of granted channel drops
module byte_download_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input logic                    clk_clk,
  input logic                    reset_reset,
  byte_download_arbiter_if.slave bus
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = CH_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_LOW = 1'b1
  } state_t;

  state_t             state_q;
  logic [NUM_CH-1:0]  ack_q;
  logic [CH_W-1:0]    gnt_q;
  logic [CH_W-1:0]    last_grant_q;

  logic [NUM_CH-1:0]  ready_s;
  logic [NUM_CH-1:0]  req;
  logic [DATA_W-1:0]  ch_byte [NUM_CH];

  logic               hi_found;
  logic               lo_found;
  logic [CH_W-1:0]    hi_idx;
  logic [CH_W-1:0]    lo_idx;
  logic [CH_W-1:0]    grant_idx;

  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [ENT_W-1:0]   head;
  logic               full;
  logic               not_empty;
  logic               push;
  logic               pop;

`ifdef READY_SYNC_EN
  logic [NUM_CH-1:0]  ready_meta_q;
  logic [NUM_CH-1:0]  ready_sync_q;

  // Two-flop synchroniser for producers outside the clk_clk domain
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ready_meta_q <= '0;
      ready_sync_q <= '0;
    end else begin
      ready_meta_q <= bus.ready_i;
      ready_sync_q <= ready_meta_q;
    end
  end

  assign ready_s = ready_sync_q;
`else
  assign ready_s = bus.ready_i;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign ch_byte[c] = bus.curbyte_i[c*DATA_W +: DATA_W];
  end

  assign req = ready_s & bus.chan_en_i;

  // Round-robin pick: lowest requester above last_grant, else lowest overall (wrap)
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (req[c]) begin
        if (CH_W'(c) > last_grant_q) begin
          hi_found = 1'b1;
          hi_idx   = CH_W'(c);
        end else begin
          lo_found = 1'b1;
          lo_idx   = CH_W'(c);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  // Full uses the pre-edge occupancy, so a pop in the same cycle never frees a slot for a push
  assign full      = (count_q == FULL_CNT);
  assign not_empty = (count_q != '0);
  assign push      = (state_q == ST_IDLE) && (hi_found || lo_found) && !full;
  assign pop       = bus.rd_en_i && not_empty;

  // Handshake FSM: grant/capture in IDLE, hold ack until the granted ready falls
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q      <= ST_IDLE;
      ack_q        <= '0;
      gnt_q        <= '0;
      last_grant_q <= LAST_CH;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (push) begin
            gnt_q   <= grant_idx;
            ack_q   <= ONE_HOT0 << grant_idx;
            state_q <= ST_WAIT_LOW;
          end
        end
        ST_WAIT_LOW: begin
          // Enable mask is deliberately ignored here: an open handshake always completes
          if (!ready_s[gnt_q]) begin
            ack_q        <= '0;
            last_grant_q <= gnt_q;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          ack_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset since reads are gated by occupancy
  always_ff @(posedge clk_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {grant_idx, ch_byte[grant_idx]};
    end
  end

  // Occupancy next-state: simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign bus.ack_o      = ack_q;
  assign bus.rd_valid_o = not_empty;
  assign bus.rd_data_o  = not_empty ? head[DATA_W-1:0] : '0;
  assign bus.rd_ch_o    = not_empty ? head[ENT_W-1:DATA_W] : '0;
  assign bus.count_o    = count_q;
  assign bus.full_o     = full;
endmodule

// File: tb/tb_byte_download_arbiter.sv
// tb_byte_download_arbiter
// Directed bench for byte_download_arbiter in its default (unsynchronised ready) build.
module tb_byte_download_arbiter;
  localparam int NUM_CH     = 2;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  byte_download_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  byte_download_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.ready_i   = '0;
    bus.rd_en_i   = 1'b0;
    bus.chan_en_i = 2'b11;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.ready_i   = '0;
    bus.curbyte_i = '0;
    bus.chan_en_i = 2'b11;
    bus.rd_en_i   = 1'b0;
    tick();
    tick();
    checks++; if (bus.ack_o !== 2'b00) begin errors++; $display("FAIL reset_ack got %b want 00", bus.ack_o); end
    checks++; if (bus.rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.rd_valid_o); end
    checks++; if (bus.count_o !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count_o); end
    checks++; if (bus.full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full_o); end
    checks++; if (bus.rd_data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.rd_data_o); end
    checks++; if (bus.rd_ch_o !== 1'b0) begin errors++; $display("FAIL reset_ch got %b want 0", bus.rd_ch_o); end
    rst = 1'b0;
    tick();
    checks++; if (bus.ack_o !== 2'b00) begin errors++; $display("FAIL reset_idle_ack got %b want 00", bus.ack_o); end
  endtask

  task automatic test_single();
    bus.curbyte_i = {8'h00, 8'hA5};
    bus.ready_i   = 2'b01;
    tick();
    checks++; if (bus.ack_o !== 2'b01) begin errors++; $display("FAIL single_ack got %b want 01", bus.ack_o); end
    checks++; if (bus.rd_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", bus.rd_valid_o); end
    checks++; if (bus.rd_data_o !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", bus.rd_data_o); end
    checks++; if (bus.rd_ch_o !== 1'b0) begin errors++; $display("FAIL single_ch got %b want 0", bus.rd_ch_o); end
    checks++; if (bus.count_o !== 5'd1) begin errors++; $display("FAIL single_count got %0d want 1", bus.count_o); end
    bus.ready_i = 2'b00;
    tick();
    checks++; if (bus.ack_o !== 2'b00) begin errors++; $display("FAIL single_ackdrop got %b want 00", bus.ack_o); end
    bus.rd_en_i = 1'b1;
    tick();
    bus.rd_en_i = 1'b0;
    checks++; if (bus.rd_valid_o !== 1'b0) begin errors++; $display("FAIL single_pop_valid got %b want 0", bus.rd_valid_o); end
    checks++; if (bus.count_o !== 5'd0) begin errors++; $display("FAIL single_pop_count got %0d want 0", bus.count_o); end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_ack;
    logic       exp_ch;
    logic [7:0] exp_data;
    do_reset();
    bus.curbyte_i = {8'h22, 8'h11};
    bus.ready_i   = 2'b11;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      if (cyc % 2 == 0) exp_ack = ((cyc / 2) % 2 == 0) ? 2'b01 : 2'b10;
      else              exp_ack = 2'b00;
      checks++; if (bus.ack_o !== exp_ack) begin errors++; $display("FAIL alt_ack cyc %0d got %b want %b", cyc, bus.ack_o, exp_ack); end
      bus.ready_i = ~bus.ack_o;
    end
    bus.ready_i = 2'b00;
    tick();
    checks++; if (bus.count_o !== 5'd6) begin errors++; $display("FAIL alt_count got %0d want 6", bus.count_o); end
    for (int i = 0; i < 6; i++) begin
      exp_ch   = 1'(i % 2);
      exp_data = (i % 2 == 0) ? 8'h11 : 8'h22;
      checks++; if (bus.rd_ch_o !== exp_ch) begin errors++; $display("FAIL alt_order_ch %0d got %b want %b", i, bus.rd_ch_o, exp_ch); end
      checks++; if (bus.rd_data_o !== exp_data) begin errors++; $display("FAIL alt_order_data %0d got %h want %h", i, bus.rd_data_o, exp_data); end
      bus.rd_en_i = 1'b1;
      tick();
      bus.rd_en_i = 1'b0;
    end
    checks++; if (bus.count_o !== 5'd0) begin errors++; $display("FAIL alt_drain got %0d want 0", bus.count_o); end
  endtask

  task automatic test_mask();
    logic [1:0] exp_ack;
    bus.chan_en_i = 2'b10;
    bus.curbyte_i = {8'h44, 8'h33};
    bus.ready_i   = 2'b11;
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick();
      exp_ack = (cyc % 2 == 0) ? 2'b10 : 2'b00;
      checks++; if (bus.ack_o !== exp_ack) begin errors++; $display("FAIL mask_ack cyc %0d got %b want %b", cyc, bus.ack_o, exp_ack); end
      bus.ready_i = {~bus.ack_o[1], 1'b1};
    end
    bus.ready_i = 2'b00;
    tick();
    checks++; if (bus.count_o !== 5'd4) begin errors++; $display("FAIL mask_count got %0d want 4", bus.count_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.rd_ch_o !== 1'b1) begin errors++; $display("FAIL mask_ch %0d got %b want 1", i, bus.rd_ch_o); end
      checks++; if (bus.rd_data_o !== 8'h44) begin errors++; $display("FAIL mask_data %0d got %h want 44", i, bus.rd_data_o); end
      bus.rd_en_i = 1'b1;
      tick();
      bus.rd_en_i = 1'b0;
    end
    bus.chan_en_i = 2'b11;
  endtask

  task automatic test_enable_clear();
    do_reset();
    bus.curbyte_i = {8'h00, 8'h3C};
    bus.ready_i   = 2'b01;
    tick();
    checks++; if (bus.ack_o !== 2'b01) begin errors++; $display("FAIL en_clr_grant got %b want 01", bus.ack_o); end
    bus.chan_en_i = 2'b00;
    tick();
    tick();
    checks++; if (bus.ack_o !== 2'b01) begin errors++; $display("FAIL en_clr_hold got %b want 01", bus.ack_o); end
    bus.ready_i = 2'b00;
    tick();
    checks++; if (bus.ack_o !== 2'b00) begin errors++; $display("FAIL en_clr_drop got %b want 00", bus.ack_o); end
    checks++; if (bus.count_o !== 5'd1) begin errors++; $display("FAIL en_clr_count got %0d want 1", bus.count_o); end
    bus.chan_en_i = 2'b11;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      bus.curbyte_i = {8'h00, 8'(8'h40 + i)};
      bus.ready_i   = 2'b01;
      tick();
      checks++; if (bus.ack_o !== 2'b01) begin errors++; $display("FAIL fill_ack %0d got %b want 01", i, bus.ack_o); end
      bus.ready_i = 2'b00;
      tick();
    end
    checks++; if (bus.count_o !== 5'd16) begin errors++; $display("FAIL full_count got %0d want 16", bus.count_o); end
    checks++; if (bus.full_o !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", bus.full_o); end
    bus.curbyte_i = {8'h00, 8'h99};
    bus.ready_i   = 2'b01;
    tick();
    tick();
    tick();
    checks++; if (bus.ack_o !== 2'b00) begin errors++; $display("FAIL full_noack got %b want 00", bus.ack_o); end
    checks++; if (bus.count_o !== 5'd16) begin errors++; $display("FAIL full_hold_count got %0d want 16", bus.count_o); end
    bus.rd_en_i = 1'b1;
    tick();
    bus.rd_en_i = 1'b0;
    checks++; if (bus.ack_o !== 2'b00) begin errors++; $display("FAIL full_pop_noack got %b want 00", bus.ack_o); end
    checks++; if (bus.count_o !== 5'd15) begin errors++; $display("FAIL full_pop_count got %0d want 15", bus.count_o); end
    checks++; if (bus.rd_data_o !== 8'h41) begin errors++; $display("FAIL full_pop_head got %h want 41", bus.rd_data_o); end
    tick();
    checks++; if (bus.ack_o !== 2'b01) begin errors++; $display("FAIL full_refill_ack got %b want 01", bus.ack_o); end
    checks++; if (bus.count_o !== 5'd16) begin errors++; $display("FAIL full_refill_count got %0d want 16", bus.count_o); end
    bus.ready_i = 2'b00;
    tick();
    checks++; if (bus.ack_o !== 2'b00) begin errors++; $display("FAIL full_refill_drop got %b want 00", bus.ack_o); end
  endtask

  task automatic test_push_pop();
    logic [7:0] exp_b [5];
    bus.rd_en_i = 1'b1;
    for (int k = 0; k < 11; k++) tick();
    bus.rd_en_i = 1'b0;
    checks++; if (bus.count_o !== 5'd5) begin errors++; $display("FAIL pp_pre_count got %0d want 5", bus.count_o); end
    checks++; if (bus.rd_data_o !== 8'h4C) begin errors++; $display("FAIL pp_pre_head got %h want 4c", bus.rd_data_o); end
    bus.curbyte_i = {8'h00, 8'h77};
    bus.ready_i   = 2'b01;
    bus.rd_en_i   = 1'b1;
    tick();
    bus.ready_i = 2'b00;
    bus.rd_en_i = 1'b0;
    checks++; if (bus.count_o !== 5'd5) begin errors++; $display("FAIL pp_count got %0d want 5", bus.count_o); end
    checks++; if (bus.ack_o !== 2'b01) begin errors++; $display("FAIL pp_ack got %b want 01", bus.ack_o); end
    checks++; if (bus.rd_data_o !== 8'h4D) begin errors++; $display("FAIL pp_head got %h want 4d", bus.rd_data_o); end
    tick();
    exp_b[0] = 8'h4D; exp_b[1] = 8'h4E; exp_b[2] = 8'h4F; exp_b[3] = 8'h99; exp_b[4] = 8'h77;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.rd_data_o !== exp_b[i]) begin errors++; $display("FAIL pp_drain %0d got %h want %h", i, bus.rd_data_o, exp_b[i]); end
      bus.rd_en_i = 1'b1;
      tick();
      bus.rd_en_i = 1'b0;
    end
    bus.rd_en_i = 1'b1;
    tick();
    tick();
    bus.rd_en_i = 1'b0;
    checks++; if (bus.count_o !== 5'd0) begin errors++; $display("FAIL empty_rd_count got %0d want 0", bus.count_o); end
    checks++; if (bus.rd_valid_o !== 1'b0) begin errors++; $display("FAIL empty_rd_valid got %b want 0", bus.rd_valid_o); end
    checks++; if (bus.full_o !== 1'b0) begin errors++; $display("FAIL empty_rd_full got %b want 0", bus.full_o); end
  endtask

  task automatic test_async_reset();
    bus.curbyte_i = {8'h00, 8'h5A};
    bus.ready_i   = 2'b01;
    tick();
    checks++; if (bus.ack_o !== 2'b01) begin errors++; $display("FAIL areset_pre_ack got %b want 01", bus.ack_o); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.ack_o !== 2'b00) begin errors++; $display("FAIL areset_ack got %b want 00", bus.ack_o); end
    checks++; if (bus.count_o !== 5'd0) begin errors++; $display("FAIL areset_count got %0d want 0", bus.count_o); end
    checks++; if (bus.rd_valid_o !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", bus.rd_valid_o); end
    bus.ready_i = 2'b00;
    rst = 1'b0;
    tick();
    checks++; if (bus.ack_o !== 2'b00) begin errors++; $display("FAIL areset_after_ack got %b want 00", bus.ack_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_mask();
    test_enable_clear();
    test_full();
    test_push_pop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
